// File: rtl/bram_arbiter_if.sv
// bram_arbiter_if: one requester port of the BRAM arbiter (request handshake plus response pulse).
interface bram_arbiter_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic                  ready;
    logic                  write;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_data;
    modport master (output valid, write, address, wdata, input ready, resp_valid, resp_data);
    modport slave (input valid, write, address, wdata, output ready, resp_valid, resp_data);
endinterface

// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one single-port BRAM between two requesters and routes responses back.
// Define BRAM_ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise port 0 has fixed priority.
module bram_arbiter #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    bram_arbiter_if.slave         p0,
    bram_arbiter_if.slave         p1,
    output logic                  ram_enable,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] input_data,
    input  logic [DATA_WIDTH-1:0] output_data
);
    localparam int L = READ_LATENCY;
    logic                  grant0, grant1;
    logic                  ram_enable_q, ram_enable_d, write_enable_q, write_enable_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0] input_data_q, input_data_d;
    logic [L:0]            tag_v_q, tag_v_d, tag_p_q, tag_p_d, tag_w_q, tag_w_d;
    logic                  resp0_valid_q, resp0_valid_d, resp1_valid_q, resp1_valid_d;
    logic [DATA_WIDTH-1:0] resp0_data_q, resp0_data_d, resp1_data_q, resp1_data_d, rdata;
`ifdef BRAM_ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;
    assign grant0 = !reset && p0.valid && (!p1.valid || last_grant_q);
    assign last_grant_d = grant0 ? 1'b0 : grant1 ? 1'b1 : last_grant_q;
`else
    assign grant0 = !reset && p0.valid;
`endif
    assign grant1 = !reset && p1.valid && !grant0;
    assign p0.ready = grant0;
    assign p1.ready = grant1;
    always_comb begin
        ram_enable_d   = grant0 || grant1;
        write_enable_d = grant0 ? p0.write : (grant1 && p1.write);
        address_d      = grant0 ? p0.address : grant1 ? p1.address : address_q;
        input_data_d   = grant0 ? p0.wdata : grant1 ? p1.wdata : input_data_q;
        // tags ride alongside the request until the BRAM data is due
        tag_v_d        = {tag_v_q[L-1:0], ram_enable_d};
        tag_p_d        = {tag_p_q[L-1:0], grant1};
        tag_w_d        = {tag_w_q[L-1:0], write_enable_d};
        rdata          = tag_w_q[L] ? '0 : output_data;
        resp0_valid_d  = tag_v_q[L] && !tag_p_q[L];
        resp1_valid_d  = tag_v_q[L] && tag_p_q[L];
        resp0_data_d   = resp0_valid_d ? rdata : resp0_data_q;
        resp1_data_d   = resp1_valid_d ? rdata : resp1_data_q;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            ram_enable_q   <= 1'b0;
            write_enable_q <= 1'b0;
            address_q      <= '0;
            input_data_q   <= '0;
            tag_v_q        <= '0;
            tag_p_q        <= '0;
            tag_w_q        <= '0;
            resp0_valid_q  <= 1'b0;
            resp1_valid_q  <= 1'b0;
            resp0_data_q   <= '0;
            resp1_data_q   <= '0;
        end else begin
            ram_enable_q   <= ram_enable_d;
            write_enable_q <= write_enable_d;
            address_q      <= address_d;
            input_data_q   <= input_data_d;
            tag_v_q        <= tag_v_d;
            tag_p_q        <= tag_p_d;
            tag_w_q        <= tag_w_d;
            resp0_valid_q  <= resp0_valid_d;
            resp1_valid_q  <= resp1_valid_d;
            resp0_data_q   <= resp0_data_d;
            resp1_data_q   <= resp1_data_d;
        end
    end
`ifdef BRAM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clock) begin
        last_grant_q <= reset ? 1'b1 : last_grant_d;
    end
`endif
    assign ram_enable    = ram_enable_q;
    assign write_enable  = write_enable_q;
    assign address       = address_q;
    assign input_data    = input_data_q;
    assign p0.resp_valid = resp0_valid_q;
    assign p1.resp_valid = resp1_valid_q;
    assign p0.resp_data  = resp0_data_q;
    assign p1.resp_data  = resp1_data_q;
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: cycle-by-cycle vector table plus reset corner sequences, with a behavioural BRAM.
module tb_bram_arbiter;
`ifdef BRAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] H = 32'h0000_1234;
    localparam logic [31:0] F = 32'h0000_01FF;
    localparam int N = 27;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ram_enable, write_enable;
    logic [8:0]  address;
    logic [31:0] input_data;
    logic [31:0] output_data = '0;
    logic [31:0] mem [512] = '{default: '0};
    int          total = 0;
    int          passed = 0;
    bram_arbiter_if i0 ();
    bram_arbiter_if i1 ();
    bram_arbiter dut (
        .clock(clock), .reset(reset), .p0(i0), .p1(i1),
        .ram_enable(ram_enable), .write_enable(write_enable), .address(address),
        .input_data(input_data), .output_data(output_data)
    );
    always #5 clock = ~clock;
    always @(posedge clock) begin
        if (ram_enable) begin
            if (write_enable) mem[address] <= input_data;
            else output_data <= mem[address];
        end
    end
    typedef struct {
        logic rst;
        logic v0, w0; logic [8:0] a0; logic [31:0] d0;
        logic v1, w1; logic [8:0] a1; logic [31:0] d1;
        logic r0, r1;
        logic rv0; logic [31:0] rd0;
        logic rv1; logic [31:0] rd1;
        logic en, we; logic [8:0] ad;
    } vec_t;
    function automatic vec_t mk(
        input logic rst,
        input logic v0, input logic w0, input logic [8:0] a0, input logic [31:0] d0,
        input logic v1, input logic w1, input logic [8:0] a1, input logic [31:0] d1,
        input logic r0, input logic r1,
        input logic rv0, input logic [31:0] rd0, input logic rv1, input logic [31:0] rd1,
        input logic en, input logic we, input logic [8:0] ad);
        vec_t t;
        t.rst = rst; t.v0 = v0; t.w0 = w0; t.a0 = a0; t.d0 = d0;
        t.v1 = v1; t.w1 = w1; t.a1 = a1; t.d1 = d1;
        t.r0 = r0; t.r1 = r1; t.rv0 = rv0; t.rd0 = rd0; t.rv1 = rv1; t.rd1 = rd1;
        t.en = en; t.we = we; t.ad = ad;
        return t;
    endfunction
    function automatic vec_t idle(input logic rst);
        return mk(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    task automatic drive(input vec_t t);
        reset = t.rst;
        i0.valid = t.v0; i0.write = t.w0; i0.address = t.a0; i0.wdata = t.d0;
        i1.valid = t.v1; i1.write = t.w1; i1.address = t.a1; i1.wdata = t.d1;
    endtask
    task automatic cyc(input vec_t t);
        @(posedge clock);
        #1 drive(t);
        @(negedge clock);
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    vec_t v [N];
    int   hit;
    initial begin
        v[0]  = mk(1, 1, 0, 1, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v[1]  = v[0];
        v[2]  = v[0];
        v[3]  = mk(0, 1, 1, 16, H, 1, 0, 16, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        v[4]  = mk(0, 0, 0, 0, 0, 1, 0, 16, 0, 0, 1, 0, 0, 0, 0, 1, 1, 16);
        v[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16);
        v[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 16);
        v[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, H, 0, 0, 16);
        v[8]  = mk(0, 1, 1, 5, DB, 0, 0, 0, 0, 1, 0, 0, 0, 0, H, 0, 0, 16);
        v[9]  = mk(0, 1, 0, 5, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, H, 1, 1, 5);
        v[10] = mk(0, 1, 1, 511, F, 0, 0, 0, 0, 1, 0, 0, 0, 0, H, 1, 0, 5);
        v[11] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, H, 1, 1, 511);
        v[12] = mk(0, 1, 0, 511, 0, 0, 0, 0, 0, 1, 0, 1, DB, 0, H, 1, 1, 0);
        v[13] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, H, 1, 0, 511);
        v[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, H, 1, 0, 0);
        v[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, F, 0, H, 0, 0, 0);
        v[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, H, 0, 0, 0);
        v[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, H, 0, 0, 0);
        v[18] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, H, 0, 0, 0);
        v[19] = mk(0, 1, 0, 5, 0, 1, 0, 16, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        v[20] = mk(0, 1, 0, 5, 0, 1, 0, 16, 0, !RR, RR, 0, 0, 0, 0, 1, 0, 5);
        v[21] = mk(0, 1, 0, 5, 0, 1, 0, 16, 0, 1, 0, 0, 0, 0, 0, 1, 0, RR ? 16 : 5);
        v[22] = mk(0, 1, 0, 5, 0, 1, 0, 16, 0, !RR, RR, 1, DB, 0, 0, 1, 0, 5);
        v[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, !RR, DB, RR, RR ? H : 0, 1, 0, RR ? 16 : 5);
        v[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DB, 0, RR ? H : 0, 0, 0, RR ? 16 : 5);
        v[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, !RR, DB, RR, RR ? H : 0, 0, 0, RR ? 16 : 5);
        v[26] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DB, 0, RR ? H : 0, 0, 0, RR ? 16 : 5);
        drive(v[0]);
        for (int i = 0; i < N; i++) begin
            cyc(v[i]);
            chk($sformatf("r%0d p0_ready", i), i0.ready, v[i].r0);
            chk($sformatf("r%0d p1_ready", i), i1.ready, v[i].r1);
            chk($sformatf("r%0d p0_resp_valid", i), i0.resp_valid, v[i].rv0);
            chk($sformatf("r%0d p0_resp_data", i), i0.resp_data, v[i].rd0);
            chk($sformatf("r%0d p1_resp_valid", i), i1.resp_valid, v[i].rv1);
            chk($sformatf("r%0d p1_resp_data", i), i1.resp_data, v[i].rd1);
            chk($sformatf("r%0d ram_enable", i), ram_enable, v[i].en);
            chk($sformatf("r%0d write_enable", i), write_enable, v[i].we);
            chk($sformatf("r%0d address", i), address, v[i].ad);
            if (v[i].en && v[i].we) chk($sformatf("r%0d input_data", i), input_data, i == 4 ? H : i == 9 ? DB : i == 11 ? F : 0);
        end
        // p1 read granted, then reset: its response must never appear
        cyc(mk(0, 0, 0, 0, 0, 1, 0, 16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("rstmid p1_ready", i1.ready, 1);
        cyc(idle(1));
        chk("rstmid ready during reset", i1.ready, 0);
        for (int k = 0; k < 6; k++) begin
            cyc(idle(0));
            chk($sformatf("rstmid p1_resp_valid c%0d", k), i1.resp_valid, 0);
        end
        // write on the pins during reset still lands in the RAM but is not acked
        cyc(mk(0, 1, 1, 7, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("rstwr p0_ready", i0.ready, 1);
        cyc(idle(1));
        chk("rstwr ram_enable", ram_enable, 1);
        chk("rstwr write_enable", write_enable, 1);
        for (int k = 0; k < 5; k++) begin
            cyc(idle(0));
            chk($sformatf("rstwr p0_resp_valid c%0d", k), i0.resp_valid, 0);
        end
        cyc(mk(0, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("rd7 p0_ready", i0.ready, 1);
        hit = -1;
        for (int k = 0; k < 8; k++) begin
            cyc(idle(0));
            if (i0.resp_valid === 1'b1) begin
                hit = k;
                chk("rd7 p0_resp_data", i0.resp_data, 32'h77);
                break;
            end
        end
        chk("rd7 response cycle", hit, 2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
